// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and ASCII helpers for the UART event formatter.
package uart_pkg;

  localparam logic [7:0] CHAR_SP = 8'h20;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StGuard
  } fmt_state_e;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Channel digit, space, timestamp digits, CR, LF.
  function automatic int unsigned LINE_LEN(input int unsigned ts_w);
    return ts_w / 4 + 4;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Single-clock FIFO with registered read data, valid the cycle after a pop.
module event_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 16
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge sys_clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rdata    <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_event_formatter.sv
// Buffers hit events and serialises each as "<ch> <ts>\r\n" through the UART write/busy handshake.
module uart_event_formatter
  import uart_pkg::*;
#(
  parameter int unsigned TS_W  = 32,
  parameter int unsigned CH_W  = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  input  logic            evt_valid_i,
  output logic            evt_ready_o,
  input  logic [CH_W-1:0] evt_ch_i,
  input  logic [TS_W-1:0] evt_ts_i,
  output logic            uart_wr_o,
  output logic [7:0]      uart_dat_o,
  input  logic            uart_busy_i,
  output logic [15:0]     drop_cnt_o
);

  localparam int unsigned Nibs    = TS_W / 4;
  localparam int unsigned LineLen = LINE_LEN(TS_W);
  localparam int unsigned IdxW    = $clog2(LineLen + 1);
  localparam int unsigned EntW    = CH_W + TS_W;

  fmt_state_e      state_q;
  logic [3:0]      ch_q;
  logic [TS_W-1:0] ts_q;
  logic [IdxW-1:0] idx_q;
  logic            wr_q;
  logic [7:0]      dat_q;
  logic [15:0]     drop_q;
  logic [7:0]      next_byte;

  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [EntW-1:0] fifo_rdata;

  assign evt_ready_o = ~fifo_full;
  assign fifo_push   = evt_valid_i & ~fifo_full;
  assign fifo_pop    = (state_q == StIdle) & ~fifo_empty;
  assign uart_wr_o   = wr_q;
  assign uart_dat_o  = dat_q;
  assign drop_cnt_o  = drop_q;

  event_fifo #(
    .WIDTH(EntW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .sys_clk_i(sys_clk_i),
    .sys_rst_i(sys_rst_i),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .wdata    ({evt_ch_i, evt_ts_i}),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  function automatic logic [7:0] line_byte(input logic [IdxW-1:0] idx, input logic [3:0] ch,
                                           input logic [TS_W-1:0] ts);
    int unsigned i;
    int unsigned k;
    logic [7:0]  b;
    i = 32'(idx);
    if (i == 0) begin
      b = hex_char(ch);
    end else if (i == 1) begin
      b = CHAR_SP;
    end else if (i < Nibs + 2) begin
      k = Nibs + 1 - i;  // most significant nibble first
      b = hex_char(4'(ts >> (4 * k)));
    end else if (i == Nibs + 2) begin
      b = CHAR_CR;
    end else begin
      b = CHAR_LF;
    end
    return b;
  endfunction

  always_comb begin
    next_byte = line_byte(idx_q, ch_q, ts_q);
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= StIdle;
      ch_q    <= '0;
      ts_q    <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      dat_q   <= '0;
      drop_q  <= '0;
    end else begin
      wr_q <= 1'b0;
      if (evt_valid_i && fifo_full && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
      case (state_q)
        StIdle: begin
          if (!fifo_empty) state_q <= StLoad;
        end
        StLoad: begin
          ch_q    <= 4'(fifo_rdata[EntW-1 -: CH_W]);
          ts_q    <= fifo_rdata[TS_W-1:0];
          idx_q   <= '0;
          state_q <= StSend;
        end
        StSend: begin
          if (!uart_busy_i) begin
            wr_q    <= 1'b1;
            dat_q   <= next_byte;
            idx_q   <= idx_q + 1'b1;
            state_q <= StGuard;
          end
        end
        StGuard: begin
          // Transmitter raises busy one cycle after the strobe; never sample it too early.
          state_q <= (idx_q == IdxW'(LineLen)) ? StIdle : StSend;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
